// File: rtl/nco_lut.sv
// Phase-accumulator NCO with a quarter-wave sine LUT and a three-stage pipeline that
// produces signed sine/cosine samples plus the legacy square outputs, all time-aligned.
module nco_lut #(
  parameter int ACC_WIDTH  = 64,
  parameter int PHASE_BITS = 10,
  parameter int OUT_WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [ACC_WIDTH-1:0]        inc_in,
  input  logic                        inc_load,
  input  logic [ACC_WIDTH-1:0]        phase_off,
  input  logic                        sync_clr,
  output logic signed [OUT_WIDTH-1:0] sin_out,
  output logic signed [OUT_WIDTH-1:0] cos_out,
  output logic                        sq_sin,
  output logic                        sq_cos,
  output logic [ACC_WIDTH-1:0]        phase_accum,
  output logic                        wrap,
  output logic                        out_valid
);

  localparam int ADDR_BITS = PHASE_BITS - 2;
  localparam int LUT_SIZE  = 1 << ADDR_BITS;
  localparam int AMP       = (1 << (OUT_WIDTH - 1)) - 1;

  // Elaboration-time sine: Taylor series is accurate here since the angle stays below pi/2.
  function automatic logic [OUT_WIDTH-1:0] lut_entry(input int k);
    real x;
    real term;
    real sum_v;
    x = 3.14159265358979323846 * (2.0 * real'(k) + 1.0) / (4.0 * real'(LUT_SIZE));
    term  = x;
    sum_v = x;
    for (int i = 1; i < 12; i++) begin
      term  = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum_v = sum_v + term;
    end
    return OUT_WIDTH'($rtoi(real'(AMP) * sum_v + 0.5));
  endfunction

  logic [OUT_WIDTH-1:0] lut_s [LUT_SIZE];

  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
    localparam logic [OUT_WIDTH-1:0] LUT_VAL = lut_entry(k);
    assign lut_s[k] = LUT_VAL;
  end

  logic [ACC_WIDTH-1:0]  inc_r;
  logic [ACC_WIDTH-1:0]  acc_nxt_s;
  logic                  carry_s;
  logic [PHASE_BITS-1:0] p_s;
  logic [PHASE_BITS-1:0] p1_r;
  logic                  v1_r;
  logic [1:0]            q_s;
  logic [ADDR_BITS-1:0]  a_s;
  logic [ADDR_BITS-1:0]  sin_addr_s;
  logic [ADDR_BITS-1:0]  cos_addr_s;
  logic [OUT_WIDTH-1:0]  sin_mag_r;
  logic [OUT_WIDTH-1:0]  cos_mag_r;
  logic                  sin_neg_r;
  logic                  cos_neg_r;
  logic                  sq_sin_r;
  logic                  sq_cos_r;
  logic                  v2_r;

  assign {carry_s, acc_nxt_s} = {1'b0, phase_accum} + {1'b0, inc_r};
  assign p_s = PHASE_BITS'((phase_accum + phase_off) >> (ACC_WIDTH - PHASE_BITS));
  assign q_s = p1_r[PHASE_BITS-1 -: 2];
  assign a_s = p1_r[ADDR_BITS-1:0];

  // Increment register and phase accumulator; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_r       <= '0;
      phase_accum <= '0;
      wrap        <= 1'b0;
    end else begin
      if (inc_load) begin
        inc_r <= inc_in;
      end
      if (sync_clr) begin
        phase_accum <= '0;
        wrap        <= 1'b0;
      end else if (en) begin
        phase_accum <= acc_nxt_s;
        wrap        <= carry_s;
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  // Quadrant folding: N-1-a is the bitwise complement of the address field.
  always_comb begin
    sin_addr_s = a_s;
    cos_addr_s = ~a_s;
    if (q_s[0]) begin
      sin_addr_s = ~a_s;
      cos_addr_s = a_s;
    end else begin
      sin_addr_s = a_s;
      cos_addr_s = ~a_s;
    end
  end

  // Three pipeline stages: offset phase, LUT lookup with signs, signed outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_r      <= '0;
      v1_r      <= 1'b0;
      sin_mag_r <= '0;
      cos_mag_r <= '0;
      sin_neg_r <= 1'b0;
      cos_neg_r <= 1'b0;
      sq_sin_r  <= 1'b0;
      sq_cos_r  <= 1'b0;
      v2_r      <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
      sq_sin    <= 1'b0;
      sq_cos    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      p1_r      <= p_s;
      v1_r      <= en & ~sync_clr;
      sin_mag_r <= lut_s[sin_addr_s];
      cos_mag_r <= lut_s[cos_addr_s];
      sin_neg_r <= q_s[1];
      cos_neg_r <= q_s[1] ^ q_s[0];
      sq_sin_r  <= ~q_s[1];
      sq_cos_r  <= ~(q_s[1] ^ q_s[0]);
      v2_r      <= v1_r;
      sin_out   <= sin_neg_r ? -sin_mag_r : sin_mag_r;
      cos_out   <= cos_neg_r ? -cos_mag_r : cos_mag_r;
      sq_sin    <= sq_sin_r;
      sq_cos    <= sq_cos_r;
      out_valid <= v2_r;
    end
  end

endmodule

// File: tb/tb_nco_lut.sv
// Directed bench for nco_lut: hand-computed 16-sample period table, phase offset,
// enable/clear/load corner sequences, a full-resolution sweep and async reset.
module tb_nco_lut;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [63:0]         inc_in;
  logic                inc_load;
  logic [63:0]         phase_off;
  logic                sync_clr;
  logic signed [11:0]  sin_out;
  logic signed [11:0]  cos_out;
  logic                sq_sin;
  logic                sq_cos;
  logic [63:0]         phase_accum;
  logic                wrap;
  logic                out_valid;

  int checks;
  int errors;

  typedef struct {
    int j;
    int s;
    int c;
    bit sqs;
    bit sqc;
  } vec_t;

  vec_t tbl [16];
  int   sin_tab [16];
  int   sweep_sin [1024];

  nco_lut dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inc_in(inc_in), .inc_load(inc_load),
    .phase_off(phase_off), .sync_clr(sync_clr), .sin_out(sin_out), .cos_out(cos_out),
    .sq_sin(sq_sin), .sq_cos(sq_cos), .phase_accum(phase_accum), .wrap(wrap),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_flush();
    en = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(-r + 0.5);
  endfunction

  initial begin
    int j;
    int mx;
    real ang;
    real rad;
    longint acc_exp;
    bit pat [8];

    checks = 0;
    errors = 0;
    sin_tab = '{6, 789, 1452, 1894, 2047, 1889, 1443, 778,
                -6, -789, -1452, -1894, -2047, -1889, -1443, -778};
    for (int k = 0; k < 16; k++) begin
      tbl[k].j   = k;
      tbl[k].s   = sin_tab[k];
      tbl[k].c   = sin_tab[(k + 4) % 16];
      tbl[k].sqs = (k < 8);
      tbl[k].sqc = (k / 4 == 0) || (k / 4 == 3);
    end

    rst_n = 1'b0; en = 1'b0; inc_in = '0; inc_load = 1'b0; phase_off = '0; sync_clr = 1'b0;
    #12;
    chk("rst_sin", sin_out, 0);
    chk("rst_cos", cos_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_acc", phase_accum, 0);
    #10 rst_n = 1'b1;

    // Main run: inc = 2^60 gives a 16-sample period.
    inc_in = 64'h1000_0000_0000_0000; inc_load = 1'b1;
    step();
    inc_load = 1'b0; en = 1'b1;
    for (int s = 1; s <= 35; s++) begin
      step();
      chk("acc", phase_accum, longint'(64'(s) << 60));
      chk("wrap", wrap, (s % 16 == 0) ? 1 : 0);
      if (s < 3) begin
        chk("valid_lat", out_valid, 0);
      end else begin
        j = (s - 3) % 16;
        chk("valid", out_valid, 1);
        chk("sin", sin_out, tbl[j].s);
        chk("cos", cos_out, tbl[j].c);
        chk("sq_sin", sq_sin, tbl[j].sqs);
        chk("sq_cos", sq_cos, tbl[j].sqc);
      end
    end

    // Quarter-turn phase offset: sine becomes the zero-offset cosine.
    clr_flush();
    phase_off = 64'h4000_0000_0000_0000;
    en = 1'b1;
    for (int s = 1; s <= 18; s++) begin
      step();
      if (s >= 3) begin
        j = (s - 3) % 16;
        chk("off_sin", sin_out, tbl[j].c);
        chk("off_cos", cos_out, tbl[(j + 8) % 16].s);
      end
    end
    phase_off = '0;

    // Enable pattern 1,0,0,1,1: accumulator holds, valid follows 3 cycles later.
    clr_flush();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    acc_exp = 0;
    for (int k = 0; k < 8; k++) begin
      en = pat[k];
      step();
      if (pat[k]) acc_exp = acc_exp + longint'(64'h1000_0000_0000_0000);
      chk("en_acc", phase_accum, acc_exp);
      chk("en_valid", out_valid, (k >= 2) ? int'(pat[k - 2]) : 0);
    end

    // Load on an enabled cycle: old increment used first.
    clr_flush();
    inc_in = 64'h0400_0000_0000_0000; inc_load = 1'b1; en = 1'b1;
    step();
    chk("load_old", phase_accum, longint'(64'h1000_0000_0000_0000));
    inc_load = 1'b0;
    step();
    chk("load_new", phase_accum, longint'(64'h1400_0000_0000_0000));

    // Clear with enable just before an overflow: no wrap, bubble in valid.
    inc_in = 64'h1000_0000_0000_0000; inc_load = 1'b1; en = 1'b0;
    step();
    inc_load = 1'b0;
    clr_flush();
    en = 1'b1;
    for (int k = 0; k < 15; k++) step();
    chk("pre_clr_acc", phase_accum, longint'(64'hF000_0000_0000_0000));
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("clr_acc", phase_accum, 0);
    chk("clr_wrap", wrap, 0);
    step();
    chk("clr_acc1", phase_accum, longint'(64'h1000_0000_0000_0000));
    chk("clr_valid1", out_valid, 1);
    step();
    chk("clr_valid2", out_valid, 0);
    step();
    chk("clr_valid3", out_valid, 1);

    // Full-resolution sweep: one phase step per sample.
    inc_in = 64'h0040_0000_0000_0000; inc_load = 1'b1; en = 1'b0;
    step();
    inc_load = 1'b0;
    clr_flush();
    en = 1'b1;
    mx = 0;
    for (int s = 1; s <= 1026; s++) begin
      step();
      if (s >= 3) begin
        j = s - 3;
        ang = 2.0 * 3.14159265358979 * (real'(j) + 0.5) / 1024.0;
        chk("sw_sin", sin_out, rnd(2047.0 * $sin(ang)));
        chk("sw_cos", cos_out, rnd(2047.0 * $cos(ang)));
        rad = $sqrt(real'(int'(sin_out) * int'(sin_out) + int'(cos_out) * int'(cos_out)));
        chk("sw_radius", ((rad - 2047.0) <= 2.0 && (2047.0 - rad) <= 2.0) ? 1 : 0, 1);
        sweep_sin[j] = int'(sin_out);
        if (int'(sin_out) > mx) mx = int'(sin_out);
        if (-int'(sin_out) > mx) mx = -int'(sin_out);
      end
    end
    for (int p = 0; p < 512; p++) chk("sw_antisym", sweep_sin[p], -sweep_sin[p + 512]);
    chk("sw_max", mx, 2047);

    // Asynchronous reset mid-stream with en held high.
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sin", sin_out, 0);
    chk("mrst_cos", cos_out, 0);
    chk("mrst_sq", {sq_sin, sq_cos, wrap}, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_acc", phase_accum, 0);
    #2 rst_n = 1'b1;
    step();
    chk("mrst_v1", out_valid, 0);
    step();
    chk("mrst_v2", out_valid, 0);
    step();
    chk("mrst_v3", out_valid, 1);
    chk("mrst_sin0", sin_out, 6);
    chk("mrst_cos0", cos_out, 2047);
    chk("mrst_frozen", phase_accum, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_lut.md
Name: nco_lut

Overview:
- Parametrised successor to the square-wave carrier NCO.
- Phase accumulator with registered, reloadable frequency word and a phase offset input.
- Quarter-wave sine LUT with quadrant folding; produces signed multi-bit sine/cosine plus the legacy 1-bit square outputs, time-aligned.
- Feeds the I/Q mixer in the SDR receive chain; enable/valid stalls and flags samples cleanly.

Parameters:
- ACC_WIDTH, 64, phase accumulator / increment / offset width (min 8).
- PHASE_BITS, 10, accumulator MSBs used as LUT phase (2 quadrant bits + PHASE_BITS-2 address bits); 4 ≤ PHASE_BITS ≤ ACC_WIDTH.
- OUT_WIDTH, 12, signed sine/cosine sample width; amplitude A = 2^(OUT_WIDTH-1)-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance accumulator and push one sample into the pipeline.
- inc_in  in  ACC_WIDTH  new phase increment (unsigned).
- inc_load  in  1  capture inc_in into the increment register.
- phase_off  in  ACC_WIDTH  phase offset added after the accumulator; sampled every cycle.
- sync_clr  in  1  synchronous clear of the accumulator.
- sin_out  out  OUT_WIDTH  signed sine sample.
- cos_out  out  OUT_WIDTH  signed cosine sample.
- sq_sin  out  1  square sine: 1 when offset phase MSB = 0.
- sq_cos  out  1  square cosine: 1 when the two offset phase MSBs are equal.
- phase_accum  out  ACC_WIDTH  current accumulator value.
- wrap  out  1  one-cycle pulse when an enabled update overflows the accumulator.
- out_valid  out  1  sin_out/cos_out/sq_* hold a sample produced under en.

Behaviour:
- Reset (rst_n low, async): inc_reg, phase_accum, all pipeline registers, sin_out, cos_out = 0; sq_sin, sq_cos, wrap, out_valid = 0. Reset mid-operation flushes the pipeline; no stale valid after release.
- Increment: inc_load=1 sets inc_reg <= inc_in. Same-cycle en uses the old inc_reg; the new value takes effect on the next enabled cycle.
- Accumulator: sync_clr=1 sets acc <= 0 and wrap <= 0 regardless of en (clear wins). Otherwise en=1 sets acc <= acc + inc_reg (mod 2^ACC_WIDTH) and wrap <= carry-out. en=0 holds acc and sets wrap <= 0.
- Stage 1: p <= (acc + phase_off)[ACC_WIDTH-1 -: PHASE_BITS], where acc is the registered pre-update value; v1 <= en & ~sync_clr.
- Stage 2: q = p[MSB:MSB-1], a = p[PHASE_BITS-3:0], N = 2^(PHASE_BITS-2).
  - Sine address: a for q even, N-1-a for q odd.
  - Cosine uses phase p + N: address N-1-a for q even, a for q odd.
  - Register both LUT words, sign flags, and v2 <= v1.
- Stage 3: register the outputs.
  - sin negative for q ∈ {2,3}; cos negative for q ∈ {1,2}; negation in two's complement.
  - sq_sin = ~p[MSB]; sq_cos = ~(p[MSB]^p[MSB-1]), pipelined with p.
  - out_valid <= v2.
- Latency: the sample for the acc value present in cycle t appears at outputs in cycle t+3. Pipeline always advances; out_valid marks bubbles. Outputs hold their last values are not guaranteed when out_valid=0 and must be ignored.
- LUT: N entries, LUT[k] = round(A·sin(2π(k+0.5)/2^PHASE_BITS)), computed at elaboration.
  - Half-sample offset makes folding exact; no ±A+1 overflow is possible.
  - Outputs never exceed ±A.
- inc_reg = 0 freezes phase with valid samples. inc_reg ≥ 2^(ACC_WIDTH-1) aliases (not an error).

Test Plan:
- Reset: assert rst_n=0 mid-stream with en=1 -> all outputs 0 within the same cycle (async); out_valid stays 0 for 3 cycles after release with en=1.
- Defaults, inc_in=2^60 loaded, en=1 continuous -> 16-sample period; wrap pulses every 16 cycles; sin_out first sample = LUT[0] = 6 (A=2047, p=0); sq_sin is 8 high then 8 low; cos leads sin by 4 samples.
- Sweep inc=2^54 over one full period (1024 samples) -> every sin²+cos² within ±2 LSB of A²-scaled reference; max |sin_out| = 2047; sin(p) = -sin(p+512) exactly.
- phase_off=2^62 with inc=2^60 -> sin_out equals the cos_out of the zero-offset run, cycle-aligned.
- inc_load with a new word on the same cycle as en -> that cycle's accumulator step uses the old inc; the next step uses the new inc. sync_clr together with en -> acc=0 next cycle and no wrap pulse.
- en toggled 1,0,0,1 -> phase_accum holds during en=0; out_valid shows the same pattern delayed 3 cycles.
